// File: rtl/cds_pkg.sv
// Shared types and width helpers for the CDS skip accumulator.
//   cds_state_e : sequencing states of the sprocket-window FSM
//   acc_w()     : width of one window sum (sample width + counter headroom)
//   pix_w()     : width of the pixel sum (window diff + skip headroom)
package cds_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_PED = 3'd1,
      ST_ACC_PED  = 3'd2,
      ST_WAIT_SIG = 3'd3,
      ST_ACC_SIG  = 3'd4
   } cds_state_e;

   localparam int PIXEL_CLUSTER_SIZE_DEF = 16;
   localparam int ADC_W_DEF              = 18;
   localparam int WIN_CNT_W_DEF          = 8;
   localparam int SKIP_W_DEF             = 10;

   function automatic int acc_w(input int adc_w, input int win_cnt_w);
      return adc_w + win_cnt_w;
   endfunction

   // One extra bit for the SIG-PED difference, SKIP_W bits for the skip sum.
   function automatic int pix_w(input int adc_w, input int win_cnt_w, input int skip_w);
      return adc_w + win_cnt_w + 1 + skip_w;
   endfunction

endpackage

// File: rtl/cds_window_acc.sv
// Integrates signed ADC samples over one sprocket window.
// Ports:
//   clk, reset     : clock, async active-low reset
//   clear          : zero sum and sample counter (wins over enable)
//   enable         : window is open this cycle
//   adc_valid      : adc_data carries a sample
//   adc_data       : signed sample
//   sum            : signed running window sum
//   sat            : a sample was dropped because the counter is full
module cds_window_acc
   import cds_pkg::*;
#(
   parameter  int ADC_W     = ADC_W_DEF,
   parameter  int WIN_CNT_W = WIN_CNT_W_DEF,
   localparam int ACC_W     = acc_w(ADC_W, WIN_CNT_W)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    enable,
   input  logic                    adc_valid,
   input  logic signed [ADC_W-1:0] adc_data,
   output logic signed [ACC_W-1:0] sum,
   output logic                    sat
);

   logic [WIN_CNT_W-1:0] cnt;
   logic                 take;
   logic                 full;

   assign take = enable & adc_valid & ~clear;
   assign full = (cnt == {WIN_CNT_W{1'b1}});
   assign sat  = take & full;

   // The counter bounds the sum, so the sum itself can never wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         sum <= '0;
      end else if (clear) begin
         cnt <= '0;
         sum <= '0;
      end else if (take && !full) begin
         cnt <= cnt + WIN_CNT_W'(1);
         sum <= sum + ACC_W'(adc_data);
      end
   end

endmodule

// File: rtl/cds_skip_accumulator.sv
// CDS skip accumulator: integrates PED/SIG sprocket windows, accumulates
// SIG-PED over skip_samples repetitions and streams one pixel per completion.
// Ports:
//   clk, reset               : clock, async active-low reset
//   running                  : sequencer running; low aborts to IDLE
//   skip_samples             : skips per pixel (0 acts as 1), latched at pixel start
//   sprocket_PED/SIG         : integration window strobes
//   adc_data, adc_valid      : signed ADC sample stream
//   pixel_data/index/valid   : output pixel, held until pixel_ready
//   pixel_ready              : downstream accept
//   cluster_done             : pulse after accepting the last index of a cluster
//   err_overlap/order/overrun/sat : sticky errors, cleared by reset or running rise
//
// state        | meaning
// ST_IDLE      | stopped; waiting for running
// ST_WAIT_PED  | waiting for a pedestal window to open
// ST_ACC_PED   | integrating pedestal samples
// ST_WAIT_SIG  | pedestal done; waiting for a signal window
// ST_ACC_SIG   | integrating signal samples; fall commits one skip
module cds_skip_accumulator
   import cds_pkg::*;
#(
   parameter  int PIXEL_CLUSTER_SIZE = PIXEL_CLUSTER_SIZE_DEF,
   parameter  int ADC_W              = ADC_W_DEF,
   parameter  int WIN_CNT_W          = WIN_CNT_W_DEF,
   parameter  int SKIP_W             = SKIP_W_DEF,
   localparam int ACC_W              = acc_w(ADC_W, WIN_CNT_W),
   localparam int PIX_W              = pix_w(ADC_W, WIN_CNT_W, SKIP_W),
   localparam int IDX_W              = $clog2(PIXEL_CLUSTER_SIZE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    running,
   input  logic [SKIP_W-1:0]       skip_samples,
   input  logic                    sprocket_PED,
   input  logic                    sprocket_SIG,
   input  logic signed [ADC_W-1:0] adc_data,
   input  logic                    adc_valid,
   output logic signed [PIX_W-1:0] pixel_data,
   output logic [IDX_W-1:0]        pixel_index,
   output logic                    pixel_valid,
   input  logic                    pixel_ready,
   output logic                    cluster_done,
   output logic                    err_overlap,
   output logic                    err_order,
   output logic                    err_overrun,
   output logic                    err_sat
);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PIXEL_CLUSTER_SIZE - 1);

   cds_state_e              state;
   logic                    ped_s1, sig_s1, vld_s1;
   logic                    ped_s2, sig_s2;
   logic signed [ADC_W-1:0] adc_s1;
   logic                    run_q;
   logic [SKIP_W-1:0]       skip_target;
   logic [SKIP_W-1:0]       skip_cnt;
   logic signed [PIX_W-1:0] pixel_acc;
   logic                    done_pend;

   logic                    overlap, active, start, commit, accept;
   logic                    ped_rise, ped_fall, sig_rise, sig_fall;
   logic                    ped_en, sig_en, win_clear;
   logic                    ped_sat, sig_sat;
   logic signed [ACC_W-1:0] ped_sum, sig_sum;
   logic signed [ACC_W:0]   diff;
   logic [SKIP_W-1:0]       skip_next;
   logic [SKIP_W-1:0]       skip_req;

   assign overlap  = ped_s1 & sig_s1;
   assign ped_rise = ped_s1 & ~ped_s2;
   assign ped_fall = ~ped_s1 & ped_s2;
   assign sig_rise = sig_s1 & ~sig_s2;
   assign sig_fall = ~sig_s1 & sig_s2;

   assign active = running & (state != ST_IDLE);
   assign start  = running & (state == ST_IDLE);
   assign commit = active & ~overlap & (state == ST_ACC_SIG) & sig_fall;
   assign accept = pixel_valid & pixel_ready;

   // The opening-edge cycle already carries the first sample of the window.
   assign ped_en = active & ~overlap & ped_s1 &
                   ((state == ST_ACC_PED) | ((state == ST_WAIT_PED) & ped_rise));
   assign sig_en = active & ~overlap & sig_s1 &
                   ((state == ST_ACC_SIG) | ((state == ST_WAIT_SIG) & sig_rise));
   assign win_clear = commit | ~running;

   assign diff      = (ACC_W+1)'(sig_sum) - (ACC_W+1)'(ped_sum);
   assign skip_next = skip_cnt + SKIP_W'(1);
   assign skip_req  = (skip_samples == '0) ? SKIP_W'(1) : skip_samples;

   cds_window_acc #(.ADC_W(ADC_W), .WIN_CNT_W(WIN_CNT_W)) u_ped_acc (
      .clk       (clk),
      .reset     (reset),
      .clear     (win_clear),
      .enable    (ped_en),
      .adc_valid (vld_s1),
      .adc_data  (adc_s1),
      .sum       (ped_sum),
      .sat       (ped_sat)
   );

   cds_window_acc #(.ADC_W(ADC_W), .WIN_CNT_W(WIN_CNT_W)) u_sig_acc (
      .clk       (clk),
      .reset     (reset),
      .clear     (win_clear),
      .enable    (sig_en),
      .adc_valid (vld_s1),
      .adc_data  (adc_s1),
      .sum       (sig_sum),
      .sat       (sig_sat)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         ped_s1       <= 1'b0;
         sig_s1       <= 1'b0;
         vld_s1       <= 1'b0;
         adc_s1       <= '0;
         ped_s2       <= 1'b0;
         sig_s2       <= 1'b0;
         run_q        <= 1'b0;
         skip_target  <= SKIP_W'(1);
         skip_cnt     <= '0;
         pixel_acc    <= '0;
         done_pend    <= 1'b0;
         pixel_data   <= '0;
         pixel_index  <= '0;
         pixel_valid  <= 1'b0;
         cluster_done <= 1'b0;
         err_overlap  <= 1'b0;
         err_order    <= 1'b0;
         err_overrun  <= 1'b0;
         err_sat      <= 1'b0;
      end else begin
         ped_s1 <= sprocket_PED;
         sig_s1 <= sprocket_SIG;
         vld_s1 <= adc_valid;
         adc_s1 <= adc_data;
         ped_s2 <= ped_s1;
         sig_s2 <= sig_s1;
         run_q  <= running;

         cluster_done <= 1'b0;
         if (accept) begin
            pixel_valid  <= 1'b0;
            pixel_index  <= (pixel_index == IDX_MAX) ? '0 : pixel_index + IDX_W'(1);
            cluster_done <= (pixel_index == IDX_MAX);
         end

         // A landing pixel wins over the clear from a same-cycle accept.
         if (done_pend) begin
            pixel_data  <= pixel_acc;
            pixel_valid <= 1'b1;
            if (pixel_valid && !pixel_ready)
               err_overrun <= 1'b1;
            pixel_acc   <= '0;
            skip_cnt    <= '0;
            done_pend   <= 1'b0;
            skip_target <= skip_req;
         end

         if (running && !run_q) begin
            err_overlap <= 1'b0;
            err_order   <= 1'b0;
            err_overrun <= 1'b0;
            err_sat     <= 1'b0;
         end

         if (!running) begin
            state     <= ST_IDLE;
            pixel_acc <= '0;
            skip_cnt  <= '0;
            done_pend <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state       <= ST_WAIT_PED;
                  skip_target <= skip_req;
                  pixel_index <= '0;
                  pixel_acc   <= '0;
                  skip_cnt    <= '0;
               end
               ST_WAIT_PED: begin
                  if (!overlap) begin
                     if (ped_rise)
                        state <= ST_ACC_PED;
                     else if (sig_rise)
                        err_order <= 1'b1;
                  end
               end
               ST_ACC_PED: begin
                  if (!overlap && ped_fall)
                     state <= ST_WAIT_SIG;
               end
               ST_WAIT_SIG: begin
                  if (!overlap && sig_rise)
                     state <= ST_ACC_SIG;
               end
               ST_ACC_SIG: begin
                  if (commit) begin
                     state     <= ST_WAIT_PED;
                     pixel_acc <= pixel_acc + PIX_W'(diff);
                     skip_cnt  <= skip_next;
                     done_pend <= (skip_next == skip_target);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end

         if (active && overlap)
            err_overlap <= 1'b1;
         if (ped_sat || sig_sat)
            err_sat <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cds_skip_accumulator.sv
// Directed/randomised bench for cds_skip_accumulator with a sum-of-samples
// reference model: pixel = sum over skips of (SIG samples - PED samples),
// each window limited to its first 255 valid samples.
module tb_cds_skip_accumulator;

   localparam int ADC_W  = 18;
   localparam int SKIP_W = 10;
   localparam int PIX_W  = 18 + 8 + 1 + 10;
   localparam int IDX_W  = 4;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    running;
   logic [SKIP_W-1:0]       skip_samples;
   logic                    sprocket_PED, sprocket_SIG;
   logic signed [ADC_W-1:0] adc_data;
   logic                    adc_valid;
   logic signed [PIX_W-1:0] pixel_data;
   logic [IDX_W-1:0]        pixel_index;
   logic                    pixel_valid;
   logic                    pixel_ready;
   logic                    cluster_done;
   logic                    err_overlap, err_order, err_overrun, err_sat;

   int     checks = 0;
   int     errors = 0;
   longint model_acc = 0;
   longint got_d[$];
   int     got_i[$];
   longint exp_d[$];
   int     done_cnt = 0;

   cds_skip_accumulator dut (
      .clk          (clk),
      .reset        (reset),
      .running      (running),
      .skip_samples (skip_samples),
      .sprocket_PED (sprocket_PED),
      .sprocket_SIG (sprocket_SIG),
      .adc_data     (adc_data),
      .adc_valid    (adc_valid),
      .pixel_data   (pixel_data),
      .pixel_index  (pixel_index),
      .pixel_valid  (pixel_valid),
      .pixel_ready  (pixel_ready),
      .cluster_done (cluster_done),
      .err_overlap  (err_overlap),
      .err_order    (err_order),
      .err_overrun  (err_overrun),
      .err_sat      (err_sat)
   );

   always #5 clk = ~clk;

   // Record every accepted pixel and every cluster_done pulse.
   always @(negedge clk) begin
      if (pixel_valid && pixel_ready) begin
         got_d.push_back(longint'(pixel_data));
         got_i.push_back(int'(pixel_index));
      end
      if (cluster_done)
         done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit p, input bit s, input int d, input bit v);
      sprocket_PED = p;
      sprocket_SIG = s;
      adc_data     = ADC_W'(d);
      adc_valid    = v;
      @(posedge clk);
      #1;
   endtask

   // mode 0: fixed value; 1: random value; 2: random value and random valid
   task automatic window(input bit is_sig, input int n, input int fixed, input int mode);
      int taken = 0;
      for (int i = 0; i < n; i++) begin
         int v;
         bit vl;
         v  = (mode == 0) ? fixed : int'($urandom_range(0, 262143)) - 131072;
         vl = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         cyc(!is_sig, is_sig, v, vl);
         if (vl && taken < 255) begin
            taken++;
            model_acc += is_sig ? longint'(v) : -longint'(v);
         end
      end
   endtask

   task automatic drive_skip(input int np, input int ns, input int pv, input int sv,
                             input int mode);
      window(1'b0, np, pv, mode);
      repeat (2) cyc(0, 0, 0, 0);
      window(1'b1, ns, sv, mode);
      repeat (2) cyc(0, 0, 0, 0);
   endtask

   task automatic restart(input int sk);
      running = 1'b0;
      repeat (3) cyc(0, 0, 0, 0);
      skip_samples = SKIP_W'(sk);
      running = 1'b1;
      repeat (2) cyc(0, 0, 0, 0);
      model_acc = 0;
      got_d.delete();
      got_i.delete();
      exp_d.delete();
      done_cnt = 0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!pixel_valid && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, pixel_valid, 1);
   endtask

   task automatic wait_pixels(input string tag, input int cnt, input int budget);
      int n = 0;
      while (got_d.size() < cnt && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, got_d.size(), cnt);
   endtask

   initial begin
      longint e;
      reset        = 1'b0;
      running      = 1'b0;
      skip_samples = '0;
      sprocket_PED = 1'b0;
      sprocket_SIG = 1'b0;
      adc_data     = '0;
      adc_valid    = 1'b0;
      pixel_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", pixel_valid, 0);
      check("rst_data", pixel_data, 0);
      check("rst_index", pixel_index, 0);
      check("rst_errs", {err_overlap, err_order, err_overrun, err_sat, cluster_done}, 0);
      reset = 1'b1;
      cyc(0, 0, 0, 0);

      // basic CDS, 10 skips of PED 4x100 / SIG 4x150
      restart(10);
      for (int k = 0; k < 10; k++)
         drive_skip(4, 4, 100, 150, 0);
      wait_valid("t1_valid", 20);
      check("t1_data", pixel_data, model_acc);
      check("t1_data_abs", pixel_data, 2000);
      check("t1_index", pixel_index, 0);
      check("t1_no_errs", {err_overlap, err_order, err_overrun, err_sat}, 0);
      pixel_ready = 1'b1;
      cyc(0, 0, 0, 0);
      pixel_ready = 1'b0;
      check("t1_drop_valid", pixel_valid, 0);
      check("t1_index_inc", pixel_index, 1);

      // cluster wrap with random windows, skip_samples=1
      restart(1);
      pixel_ready = 1'b1;
      for (int p = 0; p < 17; p++) begin
         drive_skip(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 0, 0, 2);
         exp_d.push_back(model_acc);
         model_acc = 0;
      end
      wait_pixels("t2_count", 17, 40);
      for (int i = 0; i < 17 && i < got_d.size(); i++) begin
         check($sformatf("t2_data%0d", i), got_d[i], exp_d[i]);
         check($sformatf("t2_index%0d", i), got_i[i], i % 16);
      end
      check("t2_cluster_done", done_cnt, 1);
      check("t2_no_overrun", err_overrun, 0);

      // backpressure: second pixel overwrites the first
      pixel_ready = 1'b0;
      restart(1);
      drive_skip(4, 4, 0, 50, 0);
      wait_valid("t3_valid", 20);
      check("t3_first", pixel_data, model_acc);
      model_acc = 0;
      drive_skip(4, 4, 0, 75, 0);
      repeat (6) cyc(0, 0, 0, 0);
      check("t3_second", pixel_data, model_acc);
      check("t3_second_abs", pixel_data, 300);
      check("t3_overrun", err_overrun, 1);
      check("t3_index", pixel_index, 0);
      pixel_ready = 1'b1;
      cyc(0, 0, 0, 0);

      // protocol errors: SIG before PED, then an overlap cycle inside PED
      restart(1);
      repeat (4) cyc(0, 1, 500, 1);
      repeat (4) cyc(0, 0, 0, 0);
      check("t4_order", err_order, 1);
      check("t4_no_pixel", got_d.size(), 0);
      check("t4_no_overlap_yet", err_overlap, 0);
      window(1'b0, 2, 0, 1);
      cyc(1, 1, 1000, 1);
      window(1'b0, 2, 0, 1);
      repeat (2) cyc(0, 0, 0, 0);
      window(1'b1, 3, 0, 1);
      repeat (2) cyc(0, 0, 0, 0);
      wait_pixels("t4_count", 1, 20);
      if (got_d.size() > 0)
         check("t4_data", got_d[0], model_acc);
      check("t4_overlap", err_overlap, 1);

      // abort after 5 of 10 skips, then a clean run
      restart(10);
      for (int k = 0; k < 5; k++)
         drive_skip(3, 3, 0, 0, 2);
      restart(10);
      for (int k = 0; k < 10; k++)
         drive_skip(4, 4, 100, 150, 0);
      wait_pixels("t5_count", 1, 20);
      repeat (4) cyc(0, 0, 0, 0);
      check("t5_single", got_d.size(), 1);
      if (got_d.size() > 0) begin
         check("t5_data", got_d[0], 2000);
         check("t5_index", got_i[0], 0);
      end

      // skip_samples=0 acts as 1
      restart(0);
      drive_skip(3, 3, 0, 0, 1);
      wait_pixels("t6_zero_count", 1, 20);
      if (got_d.size() > 0)
         check("t6_zero_data", got_d[0], model_acc);

      // 300-cycle PED window saturates at 255 samples
      restart(1);
      check("t6_sat_clear", err_sat, 0);
      drive_skip(300, 3, 0, 0, 1);
      e = model_acc;
      wait_pixels("t6_sat_count", 1, 20);
      if (got_d.size() > 0)
         check("t6_sat_data", got_d[0], e);
      check("t6_sat_flag", err_sat, 1);

      // async reset in the middle of a pixel
      pixel_ready = 1'b0;
      restart(1);
      repeat (3) cyc(0, 1, 7, 1);
      drive_skip(4, 4, 0, 0, 1);
      wait_valid("t7_pre_valid", 20);
      check("t7_pre_order", err_order, 1);
      window(1'b0, 3, 0, 1);
      #2;
      reset = 1'b0;
      #1;
      check("t7_valid", pixel_valid, 0);
      check("t7_data", pixel_data, 0);
      check("t7_index", pixel_index, 0);
      check("t7_errs", {err_overlap, err_order, err_overrun, err_sat, cluster_done}, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
